pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: imem_read  input  1  fetch request outstanding; imem_resp  input  1  fetch data valid this cycle.
REQ-004: dmem_read, dmem_write  input  1 each  MEM-stage access outstanding; dmem_resp  input  1  access complete this cycle.
REQ-005: id_rs1, id_rs2  input  5 each  source registers of the instruction in IF/ID; id_uses_rs1, id_uses_rs2  input  1 each  source actually read.
REQ-006: ex_is_load  input  1  ID/EX holds a load; ex_rd  input  5  its destination register.
REQ-007: mispredict  input  1  EX-stage branch/jump resolution disagrees with prediction; may be a single-cycle pulse.
REQ-008: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  load enables for PC and the four pipeline registers.
REQ-009: flush_if_id, flush_id_ex  output  1 each  flush inputs of IF/ID and ID/EX; meaningful only when the matching load is 1.
REQ-010: state  output  2  FSM state: RUN=2'b00, MEM_WAIT=2'b01, REDIRECT=2'b10.
REQ-011: stall_cycles  output  32  count of cycles with load_pc=0.
REQ-012: flush_count  output  16  count of applied flushes.

Function
REQ-013: mem_stall = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp), combinational.
REQ-014: load_use = ex_is_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-015: do_flush = mispredict | (state == REDIRECT).
REQ-016: Priority, highest first: rst, mem_stall, do_flush, load_use, normal advance.
REQ-017: mem_stall=1: all five loads 0, both flushes 0 (whole pipeline frozen, zero latency).
REQ-018: mem_stall=0 and do_flush=1: all loads 1, flush_if_id=1, flush_id_ex=1; load_use ignored.
REQ-019: mem_stall=0, do_flush=0, load_use=1: load_pc=0, load_if_id=0, load_id_ex=1 with flush_id_ex=1 (bubble), load_ex_mem=1, load_mem_wb=1, flush_if_id=0.
REQ-020: Otherwise: all loads 1, both flushes 0.
REQ-021: All load/flush outputs are combinational from inputs and state; no added cycle of latency.
REQ-022: FSM, RUN: mem_stall & mispredict -> REDIRECT; mem_stall & ~mispredict -> MEM_WAIT; else stay RUN.
REQ-023: FSM, MEM_WAIT: mem_stall & mispredict -> REDIRECT; mem_stall -> MEM_WAIT; ~mem_stall -> RUN.
REQ-024: FSM, REDIRECT: mem_stall -> REDIRECT (pending flush retained regardless of mispredict); ~mem_stall -> RUN (flush applied this cycle per REQ-018).
REQ-025: A mispredict pulse arriving during a memory stall is never lost; exactly one flush is applied on the first non-stalled cycle.
REQ-026: stall_cycles increments by 1 every non-reset cycle with load_pc=0; saturates at 32'hFFFFFFFF.
REQ-027: flush_count increments by 1 every non-reset cycle in which REQ-018 applies; saturates at 16'hFFFF.
REQ-028: Simultaneous imem and dmem stalls are one stall; cycle counted once.

Reset
REQ-029: While rst=1: all five loads 1, flush_if_id=1, flush_id_ex=1 (pipeline fills with NOPs/zero control words), counters not incremented.
REQ-030: On posedge clk with rst=1: state<=RUN, stall_cycles<=0, flush_count<=0; a pending REDIRECT is discarded.
REQ-031: First cycle after rst deasserts behaves per REQ-016..REQ-020 with state=RUN.

Verification
REQ-032: Idle pipeline, no hazards, 10 cycles -> all loads 1, flushes 0, state=RUN, stall_cycles=0.
REQ-033: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, one cycle -> load_pc=0, load_if_id=0, load_id_ex=1, flush_id_ex=1, stall_cycles=1; repeat with ex_rd=0 -> no stall.
REQ-034: dmem_read=1, dmem_resp=0 for 4 cycles then dmem_resp=1 -> loads 0 for 4 cycles, state MEM_WAIT then RUN, stall_cycles=4.
REQ-035: imem stall 3 cycles with one-cycle mispredict pulse in 2nd stall cycle -> state REDIRECT, cycle 4 shows all loads 1 and both flushes 1, flush_count=1, state=RUN.
REQ-036: mispredict=1 and load_use=1 same cycle, no stall -> flush wins: all loads 1, both flushes 1, stall_cycles unchanged.
REQ-037: rst asserted while in REDIRECT -> next cycle state=RUN, counters 0, no flush applied after rst drops.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl_if : hazard/stall request inputs and pipeline-control outputs
// Revision: 1.0
// ============================================================================
interface pipeline_ctrl_if;
  logic        imem_read;
  logic        imem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic        dmem_resp;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        mispredict;
  logic        load_pc;
  logic        load_if_id;
  logic        load_id_ex;
  logic        load_ex_mem;
  logic        load_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd, mispredict,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, state, stall_cycles, flush_count
  );

  modport slave (
    input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd, mispredict,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, state, stall_cycles, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl : 5-stage pipeline stall/flush controller with redirect FSM
// Revision: 1.0
// ============================================================================
module pipeline_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_ctrl_if.slave        bus
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_REDIRECT = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic w_mem_stall, w_load_use, w_do_flush;
  logic w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb;
  logic w_flush_if_id, w_flush_id_ex;

  assign w_mem_stall = (bus.imem_read & ~bus.imem_resp) |
                       ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp);
  assign w_load_use  = bus.ex_is_load & (bus.ex_rd != 5'd0) &
                       ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                        (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign w_do_flush  = bus.mispredict | (state_q == ST_REDIRECT);

  always_comb begin
    w_load_pc     = 1'b1;
    w_load_if_id  = 1'b1;
    w_load_id_ex  = 1'b1;
    w_load_ex_mem = 1'b1;
    w_load_mem_wb = 1'b1;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    if (rst) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (w_mem_stall) begin
      w_load_pc     = 1'b0;
      w_load_if_id  = 1'b0;
      w_load_id_ex  = 1'b0;
      w_load_ex_mem = 1'b0;
      w_load_mem_wb = 1'b0;
    end else if (w_do_flush) begin
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      w_load_pc     = 1'b0;
      w_load_if_id  = 1'b0;
      w_flush_id_ex = 1'b1;
    end
  end

  // A mispredict seen during a stall parks in REDIRECT until the stall clears.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_stall && bus.mispredict) state_d = ST_REDIRECT;
        else if (w_mem_stall)              state_d = ST_MEM_WAIT;
        else                               state_d = ST_RUN;
      end
      ST_REDIRECT: state_d = w_mem_stall ? ST_REDIRECT : ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!w_load_pc && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (!w_mem_stall && w_do_flush && (flush_count_q != 16'hFFFF))
      flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.load_pc      = w_load_pc;
  assign bus.load_if_id   = w_load_if_id;
  assign bus.load_id_ex   = w_load_id_ex;
  assign bus.load_ex_mem  = w_load_ex_mem;
  assign bus.load_mem_wb  = w_load_mem_wb;
  assign bus.flush_if_id  = w_flush_if_id;
  assign bus.flush_id_ex  = w_flush_id_ex;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_ctrl : directed scenarios plus randomized run against a reference model
// Revision: 1.0
// ============================================================================
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [6:0] C_ADV   = 7'b1111100;
  localparam logic [6:0] C_FLUSH = 7'b1111111;
  localparam logic [6:0] C_FROZE = 7'b0000000;
  localparam logic [6:0] C_BUBB  = 7'b0011101;

  wire [6:0] obs_ctrl = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                         bus.load_mem_wb, bus.flush_if_id, bus.flush_id_ex};

  // Reference model: a pending-flush flag and a "last cycle stalled" flag.
  logic        m_pend, m_wait;
  logic [31:0] m_stall;
  logic [15:0] m_flush;
  logic        e_stall, e_luse, e_flush;
  logic [6:0]  e_ctrl;
  logic [1:0]  e_state;

  always_comb begin
    e_stall = (bus.imem_read && !bus.imem_resp) ||
              ((bus.dmem_read || bus.dmem_write) && !bus.dmem_resp);
    e_luse  = bus.ex_is_load && (bus.ex_rd != 0) &&
              ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
               (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    e_flush = bus.mispredict || m_pend;
    if (rst)          e_ctrl = C_FLUSH;
    else if (e_stall) e_ctrl = C_FROZE;
    else if (e_flush) e_ctrl = C_FLUSH;
    else if (e_luse)  e_ctrl = C_BUBB;
    else              e_ctrl = C_ADV;
    e_state = m_pend ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend  <= 1'b0;
      m_wait  <= 1'b0;
      m_stall <= 32'd0;
      m_flush <= 16'd0;
    end else begin
      m_pend <= e_stall && e_flush;
      m_wait <= e_stall;
      if (!e_ctrl[6] && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 1;
      if (!e_stall && e_flush && m_flush != 16'hFFFF) m_flush <= m_flush + 1;
    end
  end

  task automatic set_idle();
    bus.imem_read = 0; bus.imem_resp = 0; bus.dmem_read = 0; bus.dmem_write = 0;
    bus.dmem_resp = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0;
    bus.id_uses_rs2 = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.mispredict = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_read = 1; bus.imem_resp = 0; bus.mispredict = 1;
    #8;
    n_cmp++;
    if (obs_ctrl !== C_FLUSH) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want %b", obs_ctrl, C_FLUSH);
    end
    advance();
    n_cmp++;
    if (bus.state !== 2'd0 || bus.stall_cycles !== 0 || bus.flush_count !== 0) begin
      n_bad++; $display("FAIL reset_regs: state %0d stall %0d flush %0d want 0/0/0",
                        bus.state, bus.stall_cycles, bus.flush_count);
    end
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #8;
      n_cmp++;
      if (obs_ctrl !== C_ADV) begin
        n_bad++; $display("FAIL idle_ctrl[%0d]: got %b want %b", i, obs_ctrl, C_ADV);
      end
      advance();
    end
    n_cmp++;
    if (bus.state !== 2'd0 || bus.stall_cycles !== 0) begin
      n_bad++; $display("FAIL idle_regs: state %0d stall %0d want 0/0", bus.state, bus.stall_cycles);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_is_load = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_uses_rs1 = 1;
    #8;
    n_cmp++;
    if (obs_ctrl !== C_BUBB) begin
      n_bad++; $display("FAIL load_use_ctrl: got %b want %b", obs_ctrl, C_BUBB);
    end
    advance();
    n_cmp++;
    if (bus.stall_cycles !== 32'd1) begin
      n_bad++; $display("FAIL load_use_count: got %0d want 1", bus.stall_cycles);
    end
    bus.ex_rd = 0; bus.id_rs1 = 0;
    #8;
    n_cmp++;
    if (obs_ctrl !== C_ADV) begin
      n_bad++; $display("FAIL load_use_x0: got %b want %b", obs_ctrl, C_ADV);
    end
    advance();
    set_idle();
  endtask

  task automatic test_dmem_stall();
    do_reset();
    bus.dmem_read = 1; bus.dmem_resp = 0;
    for (int i = 0; i < 4; i++) begin
      #8;
      n_cmp++;
      if (obs_ctrl !== C_FROZE) begin
        n_bad++; $display("FAIL dmem_frozen[%0d]: got %b want %b", i, obs_ctrl, C_FROZE);
      end
      advance();
      n_cmp++;
      if (bus.state !== 2'd1) begin
        n_bad++; $display("FAIL dmem_state[%0d]: got %0d want 1", i, bus.state);
      end
    end
    bus.dmem_resp = 1;
    #8;
    n_cmp++;
    if (obs_ctrl !== C_ADV) begin
      n_bad++; $display("FAIL dmem_release: got %b want %b", obs_ctrl, C_ADV);
    end
    advance();
    n_cmp++;
    if (bus.state !== 2'd0 || bus.stall_cycles !== 32'd4) begin
      n_bad++; $display("FAIL dmem_end: state %0d stall %0d want 0/4", bus.state, bus.stall_cycles);
    end
    set_idle();
  endtask

  task automatic test_redirect();
    do_reset();
    bus.imem_read = 1; bus.imem_resp = 0;
    advance();
    bus.mispredict = 1;
    advance();
    bus.mispredict = 0;
    n_cmp++;
    if (bus.state !== 2'd2) begin
      n_bad++; $display("FAIL redirect_state: got %0d want 2", bus.state);
    end
    advance();
    bus.imem_resp = 1;
    #8;
    n_cmp++;
    if (obs_ctrl !== C_FLUSH || bus.flush_count !== 16'd0) begin
      n_bad++; $display("FAIL redirect_apply: got %b/%0d want %b/0", obs_ctrl, bus.flush_count, C_FLUSH);
    end
    advance();
    set_idle();
    #8;
    n_cmp++;
    if (bus.flush_count !== 16'd1 || bus.state !== 2'd0 || obs_ctrl !== C_ADV) begin
      n_bad++; $display("FAIL redirect_once: flush %0d state %0d ctrl %b want 1/0/%b",
                        bus.flush_count, bus.state, obs_ctrl, C_ADV);
    end
    advance();
  endtask

  task automatic test_flush_vs_load_use();
    do_reset();
    bus.mispredict = 1;
    bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rs2 = 7; bus.id_uses_rs2 = 1;
    #8;
    n_cmp++;
    if (obs_ctrl !== C_FLUSH) begin
      n_bad++; $display("FAIL flush_wins: got %b want %b", obs_ctrl, C_FLUSH);
    end
    advance();
    n_cmp++;
    if (bus.stall_cycles !== 0 || bus.flush_count !== 16'd1) begin
      n_bad++; $display("FAIL flush_wins_cnt: stall %0d flush %0d want 0/1", bus.stall_cycles, bus.flush_count);
    end
    set_idle();
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    bus.dmem_write = 1; bus.dmem_resp = 0; bus.mispredict = 1;
    advance();
    bus.mispredict = 0;
    rst = 1'b1;
    advance();
    rst = 1'b0;
    set_idle();
    #8;
    n_cmp++;
    if (bus.state !== 2'd0 || bus.stall_cycles !== 0 || bus.flush_count !== 0 || obs_ctrl !== C_ADV) begin
      n_bad++; $display("FAIL rst_redirect: state %0d stall %0d flush %0d ctrl %b want 0/0/0/%b",
                        bus.state, bus.stall_cycles, bus.flush_count, obs_ctrl, C_ADV);
    end
    advance();
    n_cmp++;
    if (bus.flush_count !== 0) begin
      n_bad++; $display("FAIL rst_redirect_noflush: got %0d want 0", bus.flush_count);
    end
  endtask

  task automatic test_flush_saturation();
    do_reset();
    bus.mispredict = 1;
    for (int i = 0; i < 65540; i++) advance();
    n_cmp++;
    if (bus.flush_count !== 16'hFFFF || bus.stall_cycles !== 0) begin
      n_bad++; $display("FAIL flush_sat: flush %h stall %0d want ffff/0", bus.flush_count, bus.stall_cycles);
    end
    set_idle();
  endtask

  task automatic test_random();
    int bad_here;
    bad_here = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 63) == 0);
      bus.imem_read   = ($urandom_range(0, 3) == 0);
      bus.imem_resp   = $urandom_range(0, 1) != 0;
      bus.dmem_read   = ($urandom_range(0, 4) == 0);
      bus.dmem_write  = ($urandom_range(0, 6) == 0);
      bus.dmem_resp   = $urandom_range(0, 1) != 0;
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = $urandom_range(0, 1) != 0;
      bus.id_uses_rs2 = $urandom_range(0, 1) != 0;
      bus.ex_is_load  = $urandom_range(0, 1) != 0;
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.mispredict  = ($urandom_range(0, 7) == 0);
      #8;
      n_cmp++;
      if (obs_ctrl !== e_ctrl || bus.state !== e_state ||
          bus.stall_cycles !== m_stall || bus.flush_count !== m_flush) begin
        n_bad++;
        if (bad_here < 10)
          $display("FAIL random[%0d]: ctrl %b st %0d stall %0d flush %0d want %b/%0d/%0d/%0d",
                   i, obs_ctrl, bus.state, bus.stall_cycles, bus.flush_count,
                   e_ctrl, e_state, m_stall, m_flush);
        bad_here++;
      end
      advance();
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    set_idle();
    advance();
    test_reset();
    test_idle();
    test_load_use();
    test_dmem_stall();
    test_redirect();
    test_flush_vs_load_use();
    test_reset_in_redirect();
    test_random();
    test_flush_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
